// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity-mode
// encodings, the transmit FSM state set and a FIFO level-width helper.
package uart_pkg;

    // Runtime parity selection; 2'b11 is reserved and behaves as "none".
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Transmit FSM states. BREAK and MARK are only reachable when the
    // break feature is compiled in; MARK is the mark-after-break period.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5,
        ST_MARK   = 3'd6
    } uart_state_e;

    // Width needed to hold an occupancy value from 0 to depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous write FIFO for the UART transmitter. A push while full is
// dropped; a push and a pop in the same cycle leave the level unchanged.
// data_o always shows the head entry (valid whenever empty_o is low).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              data_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [level_width(DEPTH)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    count_q;
    logic [LW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Occupancy moves only when exactly one of push/pop takes effect.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + LW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - LW'(1);
        end
    end

    // Pointers and occupancy; reset flushes the FIFO.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a write FIFO and back-to-back framing.
// Optional break generation is compiled in with `define UART_TX_BREAK_EN.
//
// Write handshake: tx_data is accepted on a rising edge where tx_start and
// tx_ready are both high; tx_start with tx_ready low drops the word and
// pulses tx_overflow for one cycle. tx_start need not be held.
//
// All line-side outputs (tx, tx_busy, tx_done) are registered from the FSM
// state, so they trail the state register by one cycle. dbg_state exposes
// the current FSM state for observation.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tx_start,
    input  logic [DATA_BITS-1:0]               tx_data,
    input  logic [1:0]                         parity_mode,
`ifdef UART_TX_BREAK_EN
    input  logic                               tx_break,
`endif
    output logic                               tx_ready,
    output logic                               tx,
    output logic                               tx_busy,
    output logic                               tx_done,
    output logic [level_width(FIFO_DEPTH)-1:0] tx_level,
    output logic                               tx_overflow,
    output logic [2:0]                         dbg_state
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = 4;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);

    uart_state_e            state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [CNT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [1:0]             mode_q, mode_d;
    logic                   par_bit_q, par_bit_d;
    logic                   tx_q, busy_q, done_q, ovf_q;

    logic                   tx_next;
    logic                   baud_end;
    logic                   frame_end;
    logic                   has_parity;
    logic                   load;
    logic                   brk;

    logic [DATA_BITS-1:0]   fifo_rd;
    logic                   fifo_full;
    logic                   fifo_empty;

`ifdef UART_TX_BREAK_EN
    assign brk = tx_break;
`else
    assign brk = 1'b0;
`endif

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (tx_start),
        .data_i  (tx_data),
        .pop_i   (load),
        .data_o  (fifo_rd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (tx_level)
    );

    assign baud_end   = (baud_q == BAUD_LAST);
    assign has_parity = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);
    assign frame_end  = (state_q == ST_STOP) && baud_end && (bit_q == STOP_LAST);

    assign tx_ready    = !fifo_full;
    assign tx          = tx_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_overflow = ovf_q;
    assign dbg_state   = state_q;

    // Next-state logic: bit sequencing, baud reload and FIFO pops.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        mode_d    = mode_q;
        par_bit_d = par_bit_q;
        load      = 1'b0;

        // Baud counter free-runs within a bit and reloads on each boundary.
        if (state_q != ST_IDLE && state_q != ST_BREAK) begin
            baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (brk) begin
                    state_d = ST_BREAK;
                end else if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = has_parity ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_end) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (brk) begin
                            state_d = ST_BREAK;
                        end else if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                if (!brk) state_d = ST_MARK;
            end
            ST_MARK: begin
                if (baud_end) begin
                    if (brk) begin
                        state_d = ST_BREAK;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase

        // Popping the FIFO always starts a fresh frame with the current mode.
        if (load) begin
            state_d   = ST_START;
            baud_d    = '0;
            bit_d     = '0;
            shift_d   = fifo_rd;
            mode_d    = parity_mode;
            par_bit_d = (^fifo_rd) ^ (parity_mode == PAR_ODD);
        end
    end

    // Line level driven for the current state.
    always_comb begin
        tx_next = 1'b1;
        case (state_q)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_q[0];
            ST_PARITY: tx_next = par_bit_q;
            ST_BREAK:  tx_next = 1'b0;
            default:   tx_next = 1'b1;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            mode_q    <= PAR_NONE;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            mode_q    <= mode_d;
            par_bit_q <= par_bit_d;
        end
    end

    // Registered outputs; reset forces the line idle and cancels pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            tx_q   <= tx_next;
            busy_q <= (state_q != ST_IDLE);
            done_q <= frame_end;
            ovf_q  <= tx_start && fifo_full;
        end
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised successor to the single-word UART transmitter.
- Configurable data width, stop bits and bit period; runtime-selectable parity.
- Internal write FIFO, so software or a DMA engine can queue bursts.
- Emits back-to-back frames with no idle gap.
- Sits between the register/bus interface and the serial TX pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); legal range ≥ 2.
- DATA_BITS, 8, data bits per frame; legal range 5–9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 4, write FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset; 0 = reset.
- tx_start  in  1  write strobe; tx_data is pushed when tx_start && tx_ready.
- tx_data  in  DATA_BITS  word to send.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none (reserved).
- tx_ready  out  1  FIFO not full.
- tx  out  1  serial line; idle high; registered.
- tx_busy  out  1  a frame is on the line.
- tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit.
- tx_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- tx_overflow  out  1  one-cycle pulse when tx_start is asserted while tx_ready=0.
- tx_break  in  1  break request; present only with UART_TX_BREAK_EN.

Behaviour:
- Reset (rst=0 at a rising edge):
  - tx=1, tx_busy=0, tx_done=0, tx_overflow=0, tx_level=0, tx_ready=1.
  - FIFO is flushed; FSM goes to IDLE.
  - Reset mid-frame aborts the frame: tx returns to 1 at that edge, and no tx_done is generated.
- FIFO:
  - Synchronous FIFO; tx_ready = !full (combinational from registered count).
  - Write and pop in the same cycle are allowed, and the level is unchanged.
  - A write while full is dropped and pulses tx_overflow.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - When the FIFO is non-empty, pop the head into the shift register at edge E.
  - Latch parity_mode at E and go to START.
  - tx=0 and tx_busy=1 from edge E+1.
  - Latency: a write at edge N into an empty, idle block gives a start bit from edge N+2.
- START: holds for CLKS_PER_BIT cycles, then goes to DATA.
- DATA:
  - DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles.
  - Bit counter runs 0..DATA_BITS-1.
  - Exits to PARITY if the latched mode is even or odd; otherwise to STOP.
- PARITY:
  - Even mode sends XOR of the data bits.
  - Odd mode sends its inverse.
  - Duration is one bit period.
- STOP:
  - tx=1 for STOP_BITS bit periods.
  - tx_done pulses in the final cycle of the last stop bit.
  - If the FIFO is non-empty in that cycle: pop, and go directly to START (no idle cycle; tx_busy stays 1).
  - Otherwise go to IDLE; tx_busy=0 on the next edge.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and reloads on every bit boundary.
  - Held at 0 in IDLE.
- parity_mode changes mid-frame affect only the next frame.
- Frame length in bit periods = 1 + DATA_BITS + (parity?1:0) + STOP_BITS.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - Adds the tx_break input.
  - While tx_break=1, the FSM finishes any frame in progress, then enters state BREAK: tx=0, tx_busy=1, no FIFO pops.
  - On deassertion, tx=1 for one full bit period (mark-after-break), then IDLE; no tx_done is generated for a break.
  - tx_break asserted in IDLE enters BREAK at the next edge.
- Undefined: port, state and logic are absent; behaviour is as above.

Decomposition:
- Package uart_pkg:
  - Parity-mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD).
  - FSM state enum, including BREAK.
  - Level-width helper function.
- One sub-module, uart_tx_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with push/pop/full/empty/level.
- Baud counter and FSM stay in the top level.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with tx_start=1 → tx=1, tx_busy=0, tx_ready=1, tx_level=0, no overflow; nothing is transmitted after release.
2. CLKS_PER_BIT=4, DATA_BITS=8, no parity, STOP_BITS=1; write 0xA3 → tx = 0,1,1,0,0,0,1,0,1,1, each for 4 cycles. Start bit begins 2 edges after the write; tx_busy high for 40 cycles; one tx_done pulse in cycle 40.
3. 0xA3 with even parity → parity bit 0; odd → 1. With STOP_BITS=2 the frame is 12 bit periods (48 cycles) and the last two bits are 1.
4. FIFO_DEPTH=4; tx_start held for 6 consecutive cycles while idle → 5 words accepted, tx_ready low on the 6th write, which pulses tx_overflow. Expect 5 back-to-back frames (200 cycles) with no idle gap, 5 tx_done pulses, and tx_level back to 0.
5. Drive rst=0 during bit 3 of a frame → tx=1 at that edge, tx_busy=0, tx_level=0, no tx_done; a new write afterwards transmits normally.
6. (UART_TX_BREAK_EN) Assert tx_break mid-frame for 20 bit periods → the current frame completes, then tx=0 until deassertion, then 4 cycles of tx=1, then the queued word transmits.
